ring_osc_freq_meter: RTL and testbench



---
 rtl/ring_osc_freq_meter.sv | 113 +++++++++++
 tb/tb_ring_osc_freq_meter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_meter.sv
// Ring oscillator frequency meter: enables the oscillator, waits a settle interval,
// then counts synchronized rising edges of osc_in over a fixed window of clk cycles.
module ring_osc_freq_meter #(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             osc_in,
    output logic             osc_ena,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int GW = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             edge_det;
    logic [SW-1:0]    settle_cnt;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, cnt_nxt;
    logic             ovf_acc, ovf_nxt, sat_hit;
    logic             settle_last, gate_last;

    // osc_in is asynchronous: two flops for metastability, a third for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det    = s2 & ~s3;
    assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign gate_last   = (gate_cnt == GW'(GATE_CYCLES - 1));

    // Saturating count; overflow records an edge that arrived with the counter full
    assign sat_hit = edge_det && (edge_cnt == {CNT_W{1'b1}});
    assign cnt_nxt = (edge_det && !sat_hit) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign ovf_nxt = ovf_acc | sat_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (abort) state_nxt = IDLE;
                     else if (settle_last) state_nxt = MEASURE;
            MEASURE: if (abort) state_nxt = IDLE;
                     else if (gate_last) state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded straight from the state register so osc_ena falls with the async reset
    assign osc_ena      = (state == SETTLE) || (state == MEASURE);
    assign busy         = osc_ena;
    assign result_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_acc    <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    settle_cnt <= '0;
                    edge_cnt   <= '0;
                    ovf_acc    <= 1'b0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_last) gate_cnt <= '0;
                end
                MEASURE: begin
                    gate_cnt <= gate_cnt + GW'(1);
                    edge_cnt <= cnt_nxt;
                    ovf_acc  <= ovf_nxt;
                    if (gate_last && !abort) begin
                        result   <= cnt_nxt;
                        overflow <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: a wide and a 4-bit-counter instance share all stimulus;
// expected counts come from the recorded osc_in waveform and the window timing.
module tb_ring_osc_freq_meter;
    localparam int S = 8;
    localparam int G = 64;

    logic clk = 0, rst_n = 0, start = 0, abort = 0, osc_in = 0, result_ready = 0;
    logic osc_ena, busy, overflow, result_valid;
    logic [15:0] result;
    logic osc_ena4, busy4, overflow4, result_valid4;
    logic [3:0] result4;

    int errors = 0, checks = 0;
    int cyc = 0;
    bit hist [0:99999];
    int osc_half = 0, osc_cnt = 0;

    ring_osc_freq_meter #(.CNT_W(16), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .osc_in(osc_in),
        .osc_ena(osc_ena), .busy(busy), .result(result), .overflow(overflow),
        .result_valid(result_valid), .result_ready(result_ready));

    ring_osc_freq_meter #(.CNT_W(4), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .osc_in(osc_in),
        .osc_ena(osc_ena4), .busy(busy4), .result(result4), .overflow(overflow4),
        .result_valid(result_valid4), .result_ready(result_ready));

    always #5 clk = ~clk;

    // hist[c] is the osc_in level driven during cycle c
    always @(posedge clk) begin
        hist[cyc] = osc_in;
        cyc++;
    end

    always @(negedge clk) begin
        if (osc_half == 0) begin
            osc_in = 0;
            osc_cnt = 0;
        end else begin
            osc_cnt++;
            if (osc_cnt >= osc_half) begin
                osc_in = ~osc_in;
                osc_cnt = 0;
            end
        end
    end

    // A rise first seen in cycle r reaches the edge detector two cycles later;
    // count those landing in the window t+S+1 .. t+S+G.
    function automatic int exp_edges(int t);
        int e = 0;
        for (int c = t + S + 1; c <= t + S + G; c++)
            if (c >= 3 && hist[c-2] && !hist[c-3]) e++;
        return e;
    endfunction

    task automatic run_meas(output int t, output bit ok);
        int n = 0;
        ok = 1;
        @(negedge clk);
        start = 1;
        t = cyc;
        @(negedge clk);
        start = 0;
        checks++;
        if (osc_ena !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ena_after_start: osc_ena=%b busy=%b want 1 1", osc_ena, busy);
        end
        while (result_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            ok = 0;
            $display("FAIL valid_timeout: result_valid=%b after %0d cycles", result_valid, n);
        end else if (cyc - t != 1 + S + G) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", cyc - t, 1 + S + G);
        end
    endtask

    task automatic accept();
        result_ready = 1;
        @(negedge clk);
        result_ready = 0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL accept: valid=%b busy=%b want 0 0", result_valid, busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({osc_ena, busy, result, overflow, result_valid} !== 20'd0 ||
            {osc_ena4, busy4, result4, overflow4, result_valid4} !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: ena=%b busy=%b res=%0d ovf=%b vld=%b res4=%0d want all 0",
                     osc_ena, busy, result, overflow, result_valid, result4);
        end
    endtask

    task automatic test_basic();
        int t; bit ok;
        osc_half = 2;
        run_meas(t, ok);
        checks++;
        if (result !== 16'd16 || overflow !== 1'b0 || osc_ena !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: res=%0d ovf=%b ena=%b want 16 0 0", result, overflow, osc_ena);
        end
        checks++;
        if (result4 !== 4'd15 || overflow4 !== 1'b1) begin
            errors++;
            $display("FAIL saturate: res4=%0d ovf4=%b want 15 1", result4, overflow4);
        end
        accept();
    endtask

    task automatic test_sat_clear();
        int t; bit ok;
        osc_half = 8;
        repeat (20) @(negedge clk);
        run_meas(t, ok);
        checks++;
        if (result4 !== 4'd4 || overflow4 !== 1'b0 || result !== 16'd4) begin
            errors++;
            $display("FAIL sat_clear: res4=%0d ovf4=%b res=%0d want 4 0 4", result4, overflow4, result);
        end
        accept();
    endtask

    task automatic test_handshake();
        int t; bit ok; int bad = 0;
        osc_half = 2;
        repeat (10) @(negedge clk);
        run_meas(t, ok);
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            @(negedge clk);
            if (result_valid !== 1'b1 || result !== 16'd16 || overflow !== 1'b0 || osc_ena !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure: %0d unstable cycles, res=%0d vld=%b want 0", bad, result, result_valid);
        end
        start = 1;
        result_ready = 1;
        @(negedge clk);
        start = 0;
        result_ready = 0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || osc_ena !== 1'b0) begin
            errors++;
            $display("FAIL handshake_start_ignored: vld=%b busy=%b want 0 0", result_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_handshake: busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort();
        int t; bit seen = 0;
        osc_half = 2;
        @(negedge clk);
        start = 1;
        t = cyc;
        @(negedge clk);
        start = 0;
        while (cyc < t + S + 1 + 30) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++;
        if (osc_ena !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || result !== 16'd16) begin
            errors++;
            $display("FAIL abort: ena=%b busy=%b vld=%b res=%0d want 0 0 0 16", osc_ena, busy, result_valid, result);
        end
        repeat (100) begin
            @(negedge clk);
            if (result_valid === 1'b1 || busy === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_result: activity seen=%b want 0", seen);
        end
        abort = 1;
        repeat (3) @(negedge clk);
        abort = 0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 16'd16) begin
            errors++;
            $display("FAIL abort_idle: busy=%b vld=%b res=%0d want 0 0 16", busy, result_valid, result);
        end
    endtask

    task automatic test_async_reset();
        int t; bit ok;
        osc_half = 2;
        @(negedge clk);
        start = 1;
        t = cyc;
        @(negedge clk);
        start = 0;
        while (cyc < t + S + 20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (osc_ena !== 1'b0 || busy !== 1'b0 || result !== 16'd0 || result_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ena=%b busy=%b res=%0d vld=%b want 0 0 0 0", osc_ena, busy, result, result_valid);
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        run_meas(t, ok);
        checks++;
        if (result !== 16'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_count: res=%0d ovf=%b want 16 0", result, overflow);
        end
        accept();
    endtask

    task automatic test_no_osc();
        int t; bit ok;
        osc_half = 0;
        repeat (5) @(negedge clk);
        run_meas(t, ok);
        checks++;
        if (result !== 16'd0 || overflow !== 1'b0 || result4 !== 4'd0 || overflow4 !== 1'b0) begin
            errors++;
            $display("FAIL no_osc: res=%0d ovf=%b res4=%0d want 0 0 0", result, overflow, result4);
        end
        accept();
    endtask

    task automatic test_random();
        int t, e, e4; bit ok;
        for (int it = 0; it < 10; it++) begin
            osc_half = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 9);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            run_meas(t, ok);
            e  = exp_edges(t);
            e4 = (e > 15) ? 15 : e;
            checks++;
            if (result !== 16'(e) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL rand_count[%0d]: res=%0d ovf=%b want %0d 0", it, result, overflow, e);
            end
            checks++;
            if (result4 !== 4'(e4) || overflow4 !== (e > 15)) begin
                errors++;
                $display("FAIL rand_count4[%0d]: res4=%0d ovf4=%b want %0d %b", it, result4, overflow4, e4, e > 15);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            accept();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1;
        @(negedge clk);
        test_basic();
        test_sat_clear();
        test_handshake();
        test_abort();
        test_async_reset();
        test_no_osc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
